// File: rtl/full_subtractor.sv
// Single-bit full subtractor with an optional registered result stage and an
// optional bit-serial borrow register for LSB-first multi-bit subtraction.
module full_subtractor #(
  parameter bit SERIAL_EN = 1'b1,
  parameter bit REG_OUT   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic br_0,
  output logic out,
  output logic br,
  input  logic vld_in,
  output logic out_q,
  output logic br_q,
  output logic vld_q,
  input  logic ser_clr,
  input  logic ser_en,
  input  logic ser_a,
  input  logic ser_b,
  output logic ser_d,
  output logic ser_bo
);

  // The combinational core depends only on a/b/br_0, so serial inputs can never reach it.
  assign out = a ^ b ^ br_0;
  assign br  = (~a & b) | (~(a ^ b) & br_0);

  generate
    if (REG_OUT) begin : g_reg
      logic diff_q, diff_d;
      logic bor_q, bor_d;
      logic vld_r_q;

      always_comb begin
        diff_d = diff_q;
        bor_d  = bor_q;
        if (vld_in) begin
          diff_d = out;
          bor_d  = br;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          diff_q  <= 1'b0;
          bor_q   <= 1'b0;
          vld_r_q <= 1'b0;
        end else begin
          diff_q  <= diff_d;
          bor_q   <= bor_d;
          vld_r_q <= vld_in;
        end
      end

      assign out_q = diff_q;
      assign br_q  = bor_q;
      assign vld_q = vld_r_q;
    end else begin : g_no_reg
      assign out_q = 1'b0;
      assign br_q  = 1'b0;
      assign vld_q = 1'b0;
    end
  endgenerate

  generate
    if (SERIAL_EN) begin : g_ser
      logic bs_q, bs_d;
      logic nb;

      assign nb = (~ser_a & ser_b) | (~(ser_a ^ ser_b) & bs_q);

      // Clear takes priority over a step so a new word can start on any cycle.
      always_comb begin
        bs_d = bs_q;
        if (ser_clr) begin
          bs_d = 1'b0;
        end else if (ser_en) begin
          bs_d = nb;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bs_q <= 1'b0;
        end else begin
          bs_q <= bs_d;
        end
      end

      assign ser_d  = ser_a ^ ser_b ^ bs_q;
      assign ser_bo = bs_q;
    end else begin : g_no_ser
      assign ser_d  = 1'b0;
      assign ser_bo = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench for full_subtractor: combinational truth table, registered
// stage, asynchronous reset and LSB-first serial subtraction.
module tb_full_subtractor;

  logic clk, rst_n;
  logic a, b, br_0;
  logic out, br;
  logic vld_in, out_q, br_q, vld_q;
  logic ser_clr, ser_en, ser_a, ser_b, ser_d, ser_bo;

  int checks;
  int errs;

  full_subtractor #(.SERIAL_EN(1'b1), .REG_OUT(1'b1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .br_0   (br_0),
    .out    (out),
    .br     (br),
    .vld_in (vld_in),
    .out_q  (out_q),
    .br_q   (br_q),
    .vld_q  (vld_q),
    .ser_clr(ser_clr),
    .ser_en (ser_en),
    .ser_a  (ser_a),
    .ser_b  (ser_b),
    .ser_d  (ser_d),
    .ser_bo (ser_bo)
  );

  // One clock pulse; outputs are sampled 1 unit after the rising edge.
  task automatic tick();
    #5 clk = 1'b1;
    #1;
  endtask

  task automatic untick();
    #4 clk = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({out_q, br_q, vld_q, ser_bo} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_state: got out_q,br_q,vld_q,ser_bo=%b%b%b%b want 0000",
               out_q, br_q, vld_q, ser_bo);
    end
    #2 rst_n = 1'b1;
    #5;
  endtask

  task automatic test_comb();
    // Expected {out,br} for abc = 000..111, from the truth table.
    logic [1:0] exp_tab [8];
    logic [2:0] v;
    exp_tab = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {a, b, br_0} = v;
      #10;
      checks++;
      if ({out, br} !== exp_tab[i]) begin
        errs++;
        $display("FAIL comb_%b: got out,br=%b%b want %b", v, out, br, exp_tab[i]);
      end
    end
  endtask

  task automatic test_reg();
    // 010 with capture -> out_q=1, br_q=1
    {a, b, br_0} = 3'b010; vld_in = 1'b1;
    tick();
    checks++;
    if ({out_q, br_q, vld_q} !== 3'b111) begin
      errs++;
      $display("FAIL reg_load_010: got out_q,br_q,vld_q=%b%b%b want 111", out_q, br_q, vld_q);
    end
    untick();
    {a, b, br_0} = 3'b101; vld_in = 1'b1;
    tick();
    checks++;
    if ({out_q, br_q, vld_q} !== 3'b001) begin
      errs++;
      $display("FAIL reg_load_101: got out_q,br_q,vld_q=%b%b%b want 001", out_q, br_q, vld_q);
    end
    untick();
    {a, b, br_0} = 3'b111; vld_in = 1'b0;
    tick();
    checks++;
    if ({out_q, br_q, vld_q} !== 3'b000) begin
      errs++;
      $display("FAIL reg_hold_a: got out_q,br_q,vld_q=%b%b%b want 000", out_q, br_q, vld_q);
    end
    untick();
    {a, b, br_0} = 3'b011; vld_in = 1'b1;
    tick();
    checks++;
    if ({out_q, br_q, vld_q} !== 3'b011) begin
      errs++;
      $display("FAIL reg_load_011: got out_q,br_q,vld_q=%b%b%b want 011", out_q, br_q, vld_q);
    end
    untick();
    {a, b, br_0} = 3'b100; vld_in = 1'b0;
    tick();
    checks++;
    if ({out_q, br_q, vld_q} !== 3'b010) begin
      errs++;
      $display("FAIL reg_hold_b: got out_q,br_q,vld_q=%b%b%b want 010", out_q, br_q, vld_q);
    end
    untick();
  endtask

  task automatic test_serial();
    // 0011 - 0101 LSB first: expected digit before each step 0,1,1,1 and borrow after each step 0,0,1,1
    logic [3:0] av, bv, dexp, bexp;
    av = 4'b0011; bv = 4'b0101; dexp = 4'b1110; bexp = 4'b1100;
    ser_clr = 1'b1; ser_en = 1'b0;
    tick(); untick();
    ser_clr = 1'b0; ser_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ser_a = av[i]; ser_b = bv[i];
      #1;
      checks++;
      if (ser_d !== dexp[i]) begin
        errs++;
        $display("FAIL ser_d_bit%0d: got %b want %b", i, ser_d, dexp[i]);
      end
      tick();
      checks++;
      if (ser_bo !== bexp[i]) begin
        errs++;
        $display("FAIL ser_bo_bit%0d: got %b want %b", i, ser_bo, bexp[i]);
      end
      untick();
    end
    // hold with ser_en low: borrow stays 1
    ser_en = 1'b0; ser_a = 1'b1; ser_b = 1'b0;
    tick();
    checks++;
    if (ser_bo !== 1'b1) begin
      errs++;
      $display("FAIL ser_hold: got %b want 1", ser_bo);
    end
    untick();
  endtask

  task automatic test_clr_priority();
    // bs=1 from previous test; a=0,b=1 would keep nb=1 if enable won
    ser_clr = 1'b1; ser_en = 1'b1; ser_a = 1'b0; ser_b = 1'b1;
    tick();
    checks++;
    if (ser_bo !== 1'b0) begin
      errs++;
      $display("FAIL ser_clr_priority: got %b want 0", ser_bo);
    end
    untick();
    ser_clr = 1'b0; ser_en = 1'b0;
  endtask

  task automatic test_async_reset();
    {a, b, br_0} = 3'b010; vld_in = 1'b1;
    ser_en = 1'b1; ser_a = 1'b0; ser_b = 1'b1;
    tick(); untick();
    vld_in = 1'b0; ser_en = 1'b0;
    checks++;
    if ({out_q, br_q, vld_q, ser_bo} !== 4'b1111) begin
      errs++;
      $display("FAIL pre_reset_load: got %b%b%b%b want 1111", out_q, br_q, vld_q, ser_bo);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_q, br_q, vld_q, ser_bo} !== 4'b0000) begin
      errs++;
      $display("FAIL async_reset: got %b%b%b%b want 0000", out_q, br_q, vld_q, ser_bo);
    end
    {a, b, br_0} = 3'b100;
    #1;
    checks++;
    if ({out, br} !== 2'b10) begin
      errs++;
      $display("FAIL comb_in_reset_100: got %b%b want 10", out, br);
    end
    {a, b, br_0} = 3'b111;
    #1;
    checks++;
    if ({out, br} !== 2'b11) begin
      errs++;
      $display("FAIL comb_in_reset_111: got %b%b want 11", out, br);
    end
    // clocks during reset must not load anything
    vld_in = 1'b1;
    tick();
    checks++;
    if ({out_q, br_q, vld_q} !== 3'b000) begin
      errs++;
      $display("FAIL reset_held_clk: got %b%b%b want 000", out_q, br_q, vld_q);
    end
    untick();
    vld_in = 1'b0;
    rst_n = 1'b1;
    #2;
  endtask

  initial begin
    checks = 0; errs = 0;
    clk = 1'b0; rst_n = 1'b1;
    a = 1'b0; b = 1'b0; br_0 = 1'b0; vld_in = 1'b0;
    ser_clr = 1'b0; ser_en = 1'b0; ser_a = 1'b0; ser_b = 1'b0;
    #1;
    test_reset();
    test_comb();
    test_reg();
    test_serial();
    test_clr_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
